// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand register file: default widths,
// read-sequencer state encoding and the hardwired-zero register address.
package pe_pkg;

    localparam int PE_XLEN  = 32;
    localparam int PE_AW    = 5;
    localparam int PE_NREGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2
    } state_t;

    localparam logic [PE_AW-1:0] REG_ZERO = '0;

endpackage : pe_pkg

// File: rtl/regfile_array.sv
// Register storage with one combinational read port and one write port.
// Build option PE_REGFILE_FWD_EN selects write-first reads; default is read-first.
module regfile_array
    import pe_pkg::*;
#(
    parameter int XLEN  = PE_XLEN,
    parameter int NREGS = PE_NREGS,
    parameter int AW    = PE_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_valid;
    logic            rd_valid;

    // x0 and out-of-range addresses never hold state
    assign wr_valid = we_i && (waddr_i != AW'(REG_ZERO)) && (32'(waddr_i) < NREGS);
    assign rd_valid = (raddr_i != AW'(REG_ZERO)) && (32'(raddr_i) < NREGS);

    // NOTE: the array is cleared by reset because architectural state must read 0 after
    // reset; this keeps it in flops rather than a RAM macro, which is fine at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_valid) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rdata_o = '0;
        if (rd_valid) rdata_o = regs_q[raddr_i];
`ifdef PE_REGFILE_FWD_EN
        if (wr_valid && (waddr_i == raddr_i)) rdata_o = wdata_i;
`endif
    end

endmodule : regfile_array

// File: rtl/pe_operand_regfile.sv
// Operand server for the PE: fetches rs1 then rs2 over two cycles through a
// single read port and presents both with a one-cycle data_ready pulse.
// Build option PE_REGFILE_FWD_EN (in regfile_array) enables write-first forwarding.
module pe_operand_regfile
    import pe_pkg::*;
#(
    parameter int XLEN  = PE_XLEN,
    parameter int NREGS = PE_NREGS,
    parameter int AW    = PE_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_select,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic            rd_write,
    input  logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] a_data,
    output logic [XLEN-1:0] b_data,
    output logic            data_ready,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [AW-1:0]   rs1_q, rs2_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            ready_q;
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rdata;
    logic            accept;

    regfile_array #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .raddr_i (raddr),
        .rdata_o (rdata),
        .we_i    (rd_write),
        .waddr_i (rd_addr),
        .wdata_i (rd_data)
    );

    assign accept = (state_q == IDLE) && reg_select;
    assign raddr  = (state_q == RD_B) ? rs2_q : rs1_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (reg_select) state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == RD_B);
            if (accept) begin
                rs1_q <= rs1_addr;
                rs2_q <= rs2_addr;
            end
            if (state_q == RD_A) a_q <= rdata;
            if (state_q == RD_B) b_q <= rdata;
        end
    end

    assign a_data     = a_q;
    assign b_data     = b_q;
    assign data_ready = ready_q;
    assign busy       = (state_q != IDLE);

endmodule : pe_operand_regfile

// File: tb/tb_pe_operand_regfile.sv
// Directed bench for pe_operand_regfile: table of read vectors plus hand-written
// sequences for reset, forwarding, request-while-busy and mid-sequence reset.
module tb_pe_operand_regfile;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            reg_select;
    logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
    logic            rd_write;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] a_data, b_data;
    logic            data_ready, busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] exp_a;
        logic [XLEN-1:0] exp_b;
    } read_vec_t;

    read_vec_t vecs [7];

    pe_operand_regfile #(.XLEN(XLEN), .NREGS(32), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_select (reg_select),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rd_write   (rd_write),
        .rd_data    (rd_data),
        .a_data     (a_data),
        .b_data     (b_data),
        .data_ready (data_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [XLEN-1:0] actual,
                         input logic [XLEN-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        rd_write = 1'b1;
        rd_addr  = addr;
        rd_data  = data;
        tick();
        rd_write = 1'b0;
    endtask

    // Full read sequence with timing checks; addresses are scrambled after the
    // request edge so the result must come from the latched copies.
    task automatic run_read(input string name, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input logic [XLEN-1:0] exp_a,
                            input logic [XLEN-1:0] exp_b);
        bit seen;
        reg_select = 1'b1;
        rs1_addr   = rs1;
        rs2_addr   = rs2;
        tick();                                   // E0
        reg_select = 1'b0;
        rs1_addr   = ~rs1;
        rs2_addr   = ~rs2;
        check({name, " busy@E0"}, 32'(busy), 32'd1);
        check({name, " ready@E0"}, 32'(data_ready), 32'd0);
        tick();                                   // E1
        check({name, " busy@E1"}, 32'(busy), 32'd1);
        check({name, " ready@E1"}, 32'(data_ready), 32'd0);
        tick();                                   // E2
        seen = data_ready;
        check({name, " ready@E2"}, 32'(data_ready), 32'd1);
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = data_ready;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: data_ready never rose, expected within 3 edges", name);
        end
        check({name, " a_data"}, a_data, exp_a);
        check({name, " b_data"}, b_data, exp_b);
        check({name, " busy@E2"}, 32'(busy), 32'd0);
        tick();                                   // E3
        check({name, " ready@E3"}, 32'(data_ready), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [XLEN-1:0] exp_fwd;

        reset      = 1'b0;
        reg_select = 1'b0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        rd_addr    = '0;
        rd_write   = 1'b0;
        rd_data    = '0;

        vecs[0] = '{rs1: 5'd5,  rs2: 5'd6,  exp_a: 32'hDEADBEEF, exp_b: 32'h12345678};
        vecs[1] = '{rs1: 5'd6,  rs2: 5'd5,  exp_a: 32'h12345678, exp_b: 32'hDEADBEEF};
        vecs[2] = '{rs1: 5'd0,  rs2: 5'd0,  exp_a: 32'h0,        exp_b: 32'h0};
        vecs[3] = '{rs1: 5'd1,  rs2: 5'd31, exp_a: 32'hA5A5A5A5, exp_b: 32'h80000001};
        vecs[4] = '{rs1: 5'd31, rs2: 5'd2,  exp_a: 32'h80000001, exp_b: 32'h0000FFFF};
        vecs[5] = '{rs1: 5'd3,  rs2: 5'd0,  exp_a: 32'h0,        exp_b: 32'h0};
        vecs[6] = '{rs1: 5'd5,  rs2: 5'd5,  exp_a: 32'hDEADBEEF, exp_b: 32'hDEADBEEF};

        // Reset state
        repeat (3) tick();
        check("rst a_data", a_data, 32'h0);
        check("rst b_data", b_data, 32'h0);
        check("rst ready", 32'(data_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        run_read("post-reset r3/r4", 5'd3, 5'd4, 32'h0, 32'h0);

        // Populate registers; x0 write must be discarded
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd6, 32'h12345678);
        write_reg(5'd1, 32'hA5A5A5A5);
        write_reg(5'd2, 32'h0000FFFF);
        write_reg(5'd31, 32'h80000001);
        write_reg(5'd0, 32'hFFFFFFFF);

        for (int i = 0; i < 7; i++)
            run_read($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2,
                     vecs[i].exp_a, vecs[i].exp_b);

        // Same-cycle read/write of rs2 during RD_B
        write_reg(5'd7, 32'h1);
        reg_select = 1'b1;
        rs1_addr   = 5'd0;
        rs2_addr   = 5'd7;
        tick();                                   // E0
        reg_select = 1'b0;
        tick();                                   // E1, now in RD_B
        rd_write = 1'b1;
        rd_addr  = 5'd7;
        rd_data  = 32'h2;
        tick();                                   // E2
        rd_write = 1'b0;
`ifdef PE_REGFILE_FWD_EN
        exp_fwd = 32'h2;
`else
        exp_fwd = 32'h1;
`endif
        check("fwd ready", 32'(data_ready), 32'd1);
        check("fwd b_data", b_data, exp_fwd);
        tick();
        run_read("fwd r7 after", 5'd7, 5'd0, 32'h2, 32'h0);

        // Forwarding must never apply to x0
        reg_select = 1'b1;
        rs1_addr   = 5'd0;
        rs2_addr   = 5'd0;
        tick();
        reg_select = 1'b0;
        rd_write = 1'b1;
        rd_addr  = 5'd0;
        rd_data  = 32'hCAFEF00D;
        tick();
        tick();
        rd_write = 1'b0;
        check("x0 nofwd a", a_data, 32'h0);
        check("x0 nofwd b", b_data, 32'h0);
        tick();

        // Request while busy is ignored
        reg_select = 1'b1;
        rs1_addr   = 5'd5;
        rs2_addr   = 5'd6;
        tick();                                   // E0, now RD_A
        rs1_addr   = 5'd1;
        rs2_addr   = 5'd2;
        tick();                                   // E1 (request ignored)
        reg_select = 1'b0;
        tick();                                   // E2
        check("busy-req ready", 32'(data_ready), 32'd1);
        check("busy-req a", a_data, 32'hDEADBEEF);
        check("busy-req b", b_data, 32'h12345678);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_ready) pulses++;
        end
        check("busy-req extra pulses", 32'(pulses), 32'd0);

        // Reset in the middle of a sequence
        reg_select = 1'b1;
        rs1_addr   = 5'd5;
        rs2_addr   = 5'd6;
        tick();                                   // E0, now RD_A
        reg_select = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst a_data", a_data, 32'h0);
        check("midrst b_data", b_data, 32'h0);
        check("midrst busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_ready) pulses++;
        end
        check("midrst no ready", 32'(pulses), 32'd0);
        check("midrst idle", 32'(busy), 32'd0);
        run_read("midrst r5/r6 cleared", 5'd5, 5'd6, 32'h0, 32'h0);
        run_read("midrst r1/r31 cleared", 5'd1, 5'd31, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pe_operand_regfile
